// File: rtl/clk_div_gen_if.sv
// Control and divided-clock bundle for clk_div_gen.
// CLK_DIV_QUAD_EN adds the quadrature output dclk_q.
interface clk_div_gen_if #(
    parameter int N_CH  = 2,
    parameter int CNT_W = 8
);
    logic [N_CH-1:0]       ch_en;
    logic [N_CH*CNT_W-1:0] half_div;
    logic [N_CH-1:0]       div_upd;
    logic [N_CH-1:0]       dclk;
    logic [N_CH-1:0]       dclk_n;
    logic [N_CH-1:0]       rise_stb;
    logic [N_CH-1:0]       fall_stb;
    logic [N_CH-1:0]       busy;
`ifdef CLK_DIV_QUAD_EN
    logic [N_CH-1:0]       dclk_q;

    modport master (
        output ch_en, half_div, div_upd,
        input  dclk, dclk_n, rise_stb, fall_stb, busy, dclk_q
    );
    modport slave (
        input  ch_en, half_div, div_upd,
        output dclk, dclk_n, rise_stb, fall_stb, busy, dclk_q
    );
`else
    modport master (
        output ch_en, half_div, div_upd,
        input  dclk, dclk_n, rise_stb, fall_stb, busy
    );
    modport slave (
        input  ch_en, half_div, div_upd,
        output dclk, dclk_n, rise_stb, fall_stb, busy
    );
`endif
endinterface

// File: rtl/clk_div_gen.sv
// Multi-channel programmable clock divider with glitch-free ratio update and clean stop.
// Optional quadrature output dclk_q when CLK_DIV_QUAD_EN is defined.
//   state   | meaning
//   ST_IDLE | stopped at IDLE_LVL, act_div tracks half_div
//   ST_RUN  | dividing
//   ST_STOP | dividing until the next return to IDLE_LVL, then idle
module clk_div_gen #(
    parameter int N_CH     = 2,
    parameter int CNT_W    = 8,
    parameter bit IDLE_LVL = 1'b0
) (
    input  logic         sys_clk,
    input  logic         sys_rst,
    clk_div_gen_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    state_t           state_r  [N_CH];
    state_t           state_nx [N_CH];
    logic [CNT_W-1:0] cnt_r    [N_CH];
    logic [CNT_W-1:0] cnt_nx   [N_CH];
    logic [CNT_W-1:0] act_r    [N_CH];
    logic [CNT_W-1:0] act_nx   [N_CH];
    logic [CNT_W-1:0] pend_r   [N_CH];
    logic [CNT_W-1:0] pend_nx  [N_CH];

    logic [N_CH-1:0] pvld_r, pvld_nx;
    logic [N_CH-1:0] dclk_r, dclk_nx;
    logic [N_CH-1:0] dclkn_r;
    logic [N_CH-1:0] rise_r, rise_nx;
    logic [N_CH-1:0] fall_r, fall_nx;
    logic [N_CH-1:0] busy_w;

`ifdef CLK_DIV_QUAD_EN
    logic [N_CH-1:0] qclk_r, qclk_nx;

    // Quadrature point (act_div+1)>>1, computed one bit wider so act_div=max cannot wrap.
    function automatic logic [CNT_W-1:0] quad_pt(input logic [CNT_W-1:0] d);
        logic [CNT_W:0] s;
        s = {1'b0, d} + 1'b1;
        return s[CNT_W:1];
    endfunction
`endif

    always_comb begin
        logic [CNT_W-1:0] slice;
        logic             tc;
        logic             to_idle;

        pvld_nx = pvld_r;
        dclk_nx = dclk_r;
        rise_nx = '0;
        fall_nx = '0;
`ifdef CLK_DIV_QUAD_EN
        qclk_nx = qclk_r;
`endif
        slice   = '0;
        tc      = 1'b0;
        to_idle = 1'b0;

        for (int k = 0; k < N_CH; k++) begin
            state_nx[k] = state_r[k];
            cnt_nx[k]   = cnt_r[k];
            act_nx[k]   = act_r[k];
            pend_nx[k]  = pend_r[k];

            slice   = bus.half_div[k*CNT_W +: CNT_W];
            tc      = (cnt_r[k] == act_r[k]);
            to_idle = tc && (dclk_r[k] != IDLE_LVL);

            case (state_r[k])
                ST_IDLE: begin
                    act_nx[k]  = slice;
                    cnt_nx[k]  = '0;
                    dclk_nx[k] = IDLE_LVL;
                    pvld_nx[k] = 1'b0;
`ifdef CLK_DIV_QUAD_EN
                    qclk_nx[k] = IDLE_LVL;
`endif
                    if (bus.ch_en[k]) begin
                        state_nx[k] = ST_RUN;
                    end
                end

                ST_RUN, ST_STOP: begin
                    if (tc) begin
                        cnt_nx[k]  = '0;
                        dclk_nx[k] = ~dclk_r[k];
                        rise_nx[k] = ~dclk_r[k];
                        fall_nx[k] = dclk_r[k];
                    end else begin
                        cnt_nx[k] = cnt_r[k] + 1'b1;
                    end

                    // New ratio only takes effect at a full-period boundary.
                    if (to_idle) begin
                        if (bus.div_upd[k]) begin
                            act_nx[k]  = slice;
                            pvld_nx[k] = 1'b0;
                        end else if (pvld_r[k]) begin
                            act_nx[k]  = pend_r[k];
                            pvld_nx[k] = 1'b0;
                        end
                    end else if (bus.div_upd[k]) begin
                        pend_nx[k] = slice;
                        pvld_nx[k] = 1'b1;
                    end

                    if (!bus.ch_en[k]) begin
                        state_nx[k] = to_idle ? ST_IDLE : ST_STOP;
                    end else begin
                        state_nx[k] = ST_RUN;
                    end

`ifdef CLK_DIV_QUAD_EN
                    if (cnt_nx[k] == quad_pt(act_nx[k])) begin
                        qclk_nx[k] = ~qclk_r[k];
                    end
                    if (state_nx[k] == ST_IDLE) begin
                        qclk_nx[k] = IDLE_LVL;
                    end
`endif
                end

                default: begin
                    state_nx[k] = ST_IDLE;
                    cnt_nx[k]   = '0;
                    dclk_nx[k]  = IDLE_LVL;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            for (int k = 0; k < N_CH; k++) begin
                state_r[k] <= ST_IDLE;
                cnt_r[k]   <= '0;
                act_r[k]   <= '0;
                pend_r[k]  <= '0;
            end
            pvld_r  <= '0;
            dclk_r  <= {N_CH{IDLE_LVL}};
            dclkn_r <= {N_CH{~IDLE_LVL}};
            rise_r  <= '0;
            fall_r  <= '0;
`ifdef CLK_DIV_QUAD_EN
            qclk_r  <= {N_CH{IDLE_LVL}};
`endif
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                state_r[k] <= state_nx[k];
                cnt_r[k]   <= cnt_nx[k];
                act_r[k]   <= act_nx[k];
                pend_r[k]  <= pend_nx[k];
            end
            pvld_r  <= pvld_nx;
            dclk_r  <= dclk_nx;
            dclkn_r <= ~dclk_nx;
            rise_r  <= rise_nx;
            fall_r  <= fall_nx;
`ifdef CLK_DIV_QUAD_EN
            qclk_r  <= qclk_nx;
`endif
        end
    end

    always_comb begin
        busy_w = '0;
        for (int k = 0; k < N_CH; k++) begin
            busy_w[k] = (state_r[k] != ST_IDLE);
        end
    end

    assign bus.dclk     = dclk_r;
    assign bus.dclk_n   = dclkn_r;
    assign bus.rise_stb = rise_r;
    assign bus.fall_stb = fall_r;
    assign bus.busy     = busy_w;
`ifdef CLK_DIV_QUAD_EN
    assign bus.dclk_q   = qclk_r;
`endif

endmodule

// File: tb/tb_clk_div_gen.sv
// Bench for clk_div_gen: directed scenarios plus random traffic against an event-level model.
module tb_clk_div_gen;

    localparam int N    = 2;
    localparam int W    = 8;
    localparam bit IDLE = 1'b0;

    logic sys_clk = 1'b0;
    logic sys_rst;

    clk_div_gen_if #(.N_CH(N), .CNT_W(W)) bus ();

    clk_div_gen #(.N_CH(N), .CNT_W(W), .IDLE_LVL(IDLE)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model: per channel, cycles left until the next toggle and the current half period.
    bit m_busy [N];
    bit m_lvl  [N];
    bit m_rise [N];
    bit m_fall [N];
    bit m_pv   [N];
    int m_h    [N];
    int m_ph   [N];
    int m_left [N];
    bit m_ql   [N];
    bit m_qarm [N];
    int m_qleft[N];

    task automatic model_step();
        for (int k = 0; k < N; k++) begin
            int sl;
            bit en, up, tog, bnd;
            sl = int'(bus.half_div[k*W +: W]);
            en = bus.ch_en[k];
            up = bus.div_upd[k];
            m_rise[k] = 1'b0;
            m_fall[k] = 1'b0;
            if (sys_rst) begin
                m_busy[k] = 1'b0; m_lvl[k] = IDLE; m_pv[k] = 1'b0;
                m_ql[k] = IDLE;   m_qarm[k] = 1'b0; m_h[k] = 1; m_left[k] = 0;
            end else if (!m_busy[k]) begin
                m_h[k] = sl + 1; m_lvl[k] = IDLE; m_pv[k] = 1'b0;
                m_ql[k] = IDLE;  m_qarm[k] = 1'b0;
                if (en) begin
                    m_busy[k] = 1'b1;
                    m_left[k] = m_h[k];
                end
            end else begin
                m_left[k]--;
                tog = (m_left[k] == 0);
                bnd = tog && (m_lvl[k] != IDLE);
                if (tog) begin
                    m_lvl[k]  = ~m_lvl[k];
                    m_rise[k] = m_lvl[k];
                    m_fall[k] = ~m_lvl[k];
                end
                if (bnd) begin
                    if (up) begin
                        m_h[k] = sl + 1; m_pv[k] = 1'b0;
                    end else if (m_pv[k]) begin
                        m_h[k] = m_ph[k]; m_pv[k] = 1'b0;
                    end
                end else if (up) begin
                    m_ph[k] = sl + 1; m_pv[k] = 1'b1;
                end
                if (tog) begin
                    m_left[k] = m_h[k];
                    if ((m_h[k] >> 1) == 0) m_ql[k] = ~m_ql[k];
                    else begin
                        m_qleft[k] = m_h[k] >> 1;
                        m_qarm[k]  = 1'b1;
                    end
                end else if (m_qarm[k]) begin
                    m_qleft[k]--;
                    if (m_qleft[k] == 0) begin
                        m_ql[k] = ~m_ql[k];
                        m_qarm[k] = 1'b0;
                    end
                end
                if (bnd && !en) begin
                    m_busy[k] = 1'b0; m_ql[k] = IDLE; m_qarm[k] = 1'b0;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [N-1:0] e_d, e_n, e_r, e_f, e_b, e_q;
        for (int k = 0; k < N; k++) begin
            e_d[k] = m_lvl[k];
            e_n[k] = ~m_lvl[k];
            e_r[k] = m_rise[k];
            e_f[k] = m_fall[k];
            e_b[k] = m_busy[k];
            e_q[k] = m_ql[k];
        end
        chk("dclk", bus.dclk, e_d);
        chk("dclk_n", bus.dclk_n, e_n);
        chk("rise_stb", bus.rise_stb, e_r);
        chk("fall_stb", bus.fall_stb, e_f);
        chk("busy", bus.busy, e_b);
`ifdef CLK_DIV_QUAD_EN
        chk("dclk_q", bus.dclk_q, e_q);
`endif
    endtask

    task automatic tick();
        @(posedge sys_clk);
        model_step();
        cyc++;
        #1;
        check_all();
    endtask

    task automatic set_half(input int k, input int v);
        logic [W-1:0] t;
        t = v[W-1:0];
        bus.half_div[k*W +: W] = t;
    endtask

    task automatic wait_model_rise(input int k);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!m_rise[k] && n < 100);
        chk_int("wait_rise_budget", int'(m_rise[k]), 1);
    endtask

    task automatic wait_model_idle(input int k);
        int n;
        n = 0;
        while (m_busy[k] && n < 100) begin
            tick();
            n++;
        end
        chk_int("wait_idle_budget", int'(m_busy[k]), 0);
    endtask

    // Ticks until the DUT shows an event on channel k: 0 rise, 1 fall, 2 busy low.
    task automatic ticks_until(input int k, input int sel, output int n);
        bit hit;
        n = 0;
        do begin
            tick();
            n++;
            case (sel)
                0:       hit = bus.rise_stb[k];
                1:       hit = bus.fall_stb[k];
                default: hit = ~bus.busy[k];
            endcase
        end while (!hit && n < 64);
    endtask

    initial begin
        int n, r0, r1;
        sys_rst      = 1'b1;
        bus.ch_en    = '0;
        bus.half_div = '0;
        bus.div_upd  = '0;
        tick();
        tick();

        // half_div 3 on ch0, 0 on ch1, both enabled straight out of reset
        sys_rst = 1'b0;
        set_half(0, 3);
        set_half(1, 0);
        bus.ch_en = 2'b11;
        r0 = 0; r1 = 0;
        repeat (40) begin
            tick();
            r0 += int'(bus.rise_stb[0]);
            r1 += int'(bus.rise_stb[1]);
        end
        chk_int("rises_div3", r0, 5);
        chk_int("rises_div0", r1, 20);

        // ratio 3 -> 1 requested mid-high-phase
        wait_model_rise(0);
        tick();
        tick();
        set_half(0, 1);
        bus.div_upd = 2'b01;
        tick();
        bus.div_upd = '0;
        ticks_until(0, 1, n);
        chk_int("upd_old_period_end", n, 1);
        ticks_until(0, 1, n);
        chk_int("upd_new_period", n, 4);
        ticks_until(0, 1, n);
        chk_int("upd_new_period2", n, 4);

        // clean stop, then re-enable during STOP
        bus.ch_en = '0;
        wait_model_idle(0);
        wait_model_idle(1);
        set_half(0, 3);
        bus.ch_en = 2'b01;
        wait_model_rise(0);
        bus.ch_en = '0;
        ticks_until(0, 2, n);
        chk_int("stop_to_idle", n, 4);
        bus.ch_en = 2'b01;
        wait_model_rise(0);
        bus.ch_en = '0;
        tick();
        tick();
        bus.ch_en = 2'b01;
        repeat (20) tick();

        // synchronous reset mid-high-phase on both channels, then restart
        set_half(1, 5);
        bus.ch_en = 2'b11;
        wait_model_rise(1);
        tick();
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        ticks_until(0, 0, n);
        chk_int("restart_first_rise", n, 5);
        repeat (12) tick();

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 15) == 0) bus.ch_en[k] = ~bus.ch_en[k];
                if ($urandom_range(0, 9) == 0) set_half(k, int'($urandom_range(0, 6)));
                bus.div_upd[k] = ($urandom_range(0, 7) == 0);
            end
            sys_rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        sys_rst = 1'b0;
        bus.div_upd = '0;
        repeat (10) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
